apb_regfile_target: RTL
=======================

Name: apb_regfile_target

Overview:
- APB completer on the clk_b side of the async bridge. Consumes the bridge's paddr_b/pwdata_b/pwrite_b/psel_b/penable_b strobe and returns prdata_b/pready_b.
- Holds a small register bank: control, statistics, W1C interrupt status and scratch registers.
- Inserts a programmable number of wait states before responding.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (min 4, power of 2).
- WAIT_CYCLES, 2, idle cycles between request capture and pready_b (0..15).
- ADDR_LSB, 2, byte-offset bits below the word index.

Ports:
- clk_b  in  1  B-domain clock.
- rst_b_n  in  1  asynchronous active-low reset.
- paddr_b  in  32  transfer address.
- pwdata_b  in  32  write data.
- pwrite_b  in  1  1 = write, 0 = read.
- psel_b  in  1  select.
- penable_b  in  1  enable; the bridge asserts it in the same cycle as psel_b.
- prdata_b  out  32  read data, valid while pready_b=1.
- pready_b  out  1  one-cycle completion pulse.
- pslverr_b  out  1  error flag, valid while pready_b=1.
- ctrl_b  out  32  live copy of CTRL.
- irq_b  out  1  level interrupt.

Behaviour:
- Interface decision: one clock (clk_b); reset rst_b_n is asynchronous and active-low.
- Reset values: all registers 0, FSM in IDLE, prdata_b=0, pready_b=0, pslverr_b=0, irq_b=0, ctrl_b=0.
- Reset mid-transaction aborts the transfer with no response and no write commit.
- Register map (word index = paddr_b[ADDR_LSB +: log2(NUM_REGS)]):
  - 0 CTRL: RW.
  - 1 STATS: RO, {wr_cnt[15:0], rd_cnt[15:0]}.
  - 2 IRQ_STAT: W1C; bit0 write error, bit1 read error, bit2 overrun.
  - 3..NUM_REGS-1 SCRATCH: RW.
- Error conditions, any of which makes the access an error:
  - paddr_b[1:0] != 0;
  - paddr_b >= NUM_REGS*4;
  - a write to STATS.
- Error behaviour: pslverr_b=1, no register write, prdata_b=0 on errored reads. Sets IRQ_STAT bit0 (write) or bit1 (read).
- Statistics counters:
  - wr_cnt and rd_cnt increment only on non-error completions (cycle where pready_b=1).
  - Both saturate at 0xFFFF.
- irq_b = |(IRQ_STAT[2:0] & CTRL[2:0]), registered (one-cycle lag after a source change).
- FSM:
  - IDLE: when psel_b & penable_b, capture addr/wdata/write. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
  - WAIT: decrement the counter; go to RESP after it reaches 0.
  - RESP: pready_b=1 for exactly one cycle, prdata_b/pslverr_b valid, write committed on this clock edge; return to IDLE.
- Latency: a request captured at edge N gives pready_b high in cycle N+1+WAIT_CYCLES. Back-to-back requests are accepted from IDLE on the cycle after RESP.
- The captured request is held internally. psel_b/penable_b need not stay high, because the bridge drops them after one cycle.
- Overrun: psel_b & penable_b in WAIT or RESP is dropped (no second response) and sets IRQ_STAT bit2.
- Simultaneous events:
  - A W1C clear and a hardware set of the same IRQ_STAT bit in the same cycle: set wins.
  - A read of STATS in the same cycle as a counter increment returns the pre-increment value.
- Reads of CTRL/SCRATCH return the last committed value. A read issued right after a write to the same register sees the new data.
- prdata_b and pslverr_b are 0 whenever pready_b=0.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0C and read 0x0C with WAIT_CYCLES=2 -> pready_b rises 3 cycles after each capture; read returns 0xDEADBEEF with pslverr_b=0; STATS reads 0x0001_0001 afterwards.
- Write to 0x04, then read 0x22 (misaligned) and 0x40 (out of range) -> each gives pslverr_b=1 and prdata_b=0; IRQ_STAT=0x3; STATS is unchanged by the errored accesses.
- CTRL=0x7 with IRQ_STAT bit0 set -> irq_b=1; write 0x1 to 0x08 -> IRQ_STAT=0, and irq_b falls one cycle after the commit.
- Second psel_b&penable_b pulse during WAIT -> exactly one pready_b pulse; IRQ_STAT bit2=1; the first request's data is committed unaltered.
- Drive 65,540 successful writes -> wr_cnt saturates and holds at 0xFFFF.
- Assert rst_b_n low during WAIT of a write to 0x10 -> outputs go to 0 immediately; no pready_b; a subsequent read of 0x10 returns 0.

Source files
------------

// File: rtl/apb_regfile_target_if.sv
// apb_regfile_target_if
//   APB strobe bundle between the async bridge (master) and the clk_b-side
//   register target (slave).
//
//   Handshake: the master raises psel_b and penable_b together for a single
//   cycle to launch a transfer, with paddr_b/pwdata_b/pwrite_b valid in that
//   same cycle. The slave captures the request on that edge and later answers
//   with a one-cycle pready_b pulse. prdata_b and pslverr_b are meaningful only
//   while pready_b=1 and are held at 0 otherwise. Exactly one pready_b pulse is
//   returned per accepted request. A strobe arriving while a request is still
//   in flight is not accepted and gets no response.
//
//   Signals:
//     paddr_b   [31:0]  transfer address      (master -> slave)
//     pwdata_b  [31:0]  write data            (master -> slave)
//     pwrite_b          1 = write, 0 = read   (master -> slave)
//     psel_b            select                (master -> slave)
//     penable_b         enable                (master -> slave)
//     prdata_b  [31:0]  read data             (slave -> master)
//     pready_b          completion pulse      (slave -> master)
//     pslverr_b         error flag            (slave -> master)
interface apb_regfile_target_if;
  logic [31:0] paddr_b;
  logic [31:0] pwdata_b;
  logic        pwrite_b;
  logic        psel_b;
  logic        penable_b;
  logic [31:0] prdata_b;
  logic        pready_b;
  logic        pslverr_b;

  modport master (
    output paddr_b, pwdata_b, pwrite_b, psel_b, penable_b,
    input  prdata_b, pready_b, pslverr_b
  );

  modport slave (
    input  paddr_b, pwdata_b, pwrite_b, psel_b, penable_b,
    output prdata_b, pready_b, pslverr_b
  );
endinterface

// File: rtl/apb_regfile_target.sv
// apb_regfile_target
//   APB completer on the clk_b side of the async bridge. Holds a small
//   register bank (CTRL, STATS, W1C IRQ_STAT, SCRATCH) and answers each
//   captured request after WAIT_CYCLES idle cycles.
//
//   Register map (word index = paddr_b[ADDR_LSB +: log2(NUM_REGS)]):
//     0           CTRL      RW
//     1           STATS     RO  {wr_cnt[15:0], rd_cnt[15:0]}
//     2           IRQ_STAT  W1C bit0 write error, bit1 read error, bit2 overrun
//     3..N-1      SCRATCH   RW
//
//   Ports:
//     clk_b        B-domain clock
//     rst_b_n      asynchronous active-low reset
//     apb          APB slave modport (see apb_regfile_target_if)
//     ctrl_b       live copy of CTRL
//     irq_b        level interrupt, |(IRQ_STAT[2:0] & CTRL[2:0]) registered
//     dbg_state    current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
//   STATS_RESET is the reset value of {wr_cnt, rd_cnt}. It defaults to 0; a
//   nonzero value lets the saturation behaviour be reached without tens of
//   thousands of transfers.
module apb_regfile_target #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_LSB    = 2,
  parameter logic [31:0] STATS_RESET = 32'h0
) (
  input  logic                  clk_b,
  input  logic                  rst_b_n,
  apb_regfile_target_if.slave   apb,
  output logic [31:0]           ctrl_b,
  output logic                  irq_b,
  output logic [1:0]            dbg_state
);

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS << ADDR_LSB);
  localparam logic [IDX_W-1:0] IDX_CTRL  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATS = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_IRQ   = IDX_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_write;

  // Entries 1 and 2 are never written; STATS and IRQ_STAT live elsewhere.
  logic [31:0] mem [NUM_REGS];
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [2:0]  irq_stat;

  // Request being decided on this cycle: straight from the bus while IDLE
  // (needed when WAIT_CYCLES=0), otherwise the captured copy.
  logic [31:0]      req_addr;
  logic             req_write;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic [31:0]      rd_data;
  logic [31:0]      resp_data;
  logic [IDX_W-1:0] cap_idx;
  logic [2:0]       irq_set;
  logic [2:0]       irq_clr;
  logic             strobe;

  assign strobe    = apb.psel_b && apb.penable_b;
  assign cap_idx   = cap_addr[ADDR_LSB +: IDX_W];
  assign ctrl_b    = mem[IDX_CTRL];
  assign dbg_state = state;

  always_comb begin
    req_addr  = cap_addr;
    req_write = cap_write;
    if (state == S_IDLE) begin
      req_addr  = apb.paddr_b;
      req_write = apb.pwrite_b;
    end
    req_idx = req_addr[ADDR_LSB +: IDX_W];
    req_err = (|req_addr[ADDR_LSB-1:0]) ||
              (req_addr >= ADDR_LIMIT) ||
              (req_write && (req_idx == IDX_STATS));

    case (req_idx)
      IDX_STATS: rd_data = {wr_cnt, rd_cnt};
      IDX_IRQ:   rd_data = {29'd0, irq_stat};
      default:   rd_data = mem[req_idx];
    endcase
    resp_data = (req_err || req_write) ? 32'd0 : rd_data;
  end

  // Interrupt sources. The error bits and W1C clear act on the RESP edge,
  // i.e. when the access completes; overrun is flagged on the stray strobe.
  always_comb begin
    irq_set    = 3'b000;
    irq_clr    = 3'b000;
    irq_set[2] = strobe && (state != S_IDLE);
    if (state == S_RESP) begin
      irq_set[0] = apb.pslverr_b && cap_write;
      irq_set[1] = apb.pslverr_b && !cap_write;
      if (!apb.pslverr_b && cap_write && (cap_idx == IDX_IRQ))
        irq_clr = cap_wdata[2:0];
    end
  end

  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      state         <= S_IDLE;
      wait_cnt      <= 4'd0;
      cap_addr      <= 32'd0;
      cap_wdata     <= 32'd0;
      cap_write     <= 1'b0;
      wr_cnt        <= STATS_RESET[31:16];
      rd_cnt        <= STATS_RESET[15:0];
      irq_stat      <= 3'b000;
      irq_b         <= 1'b0;
      apb.pready_b  <= 1'b0;
      apb.prdata_b  <= 32'd0;
      apb.pslverr_b <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 32'd0;
    end else begin
      apb.pready_b  <= 1'b0;
      apb.prdata_b  <= 32'd0;
      apb.pslverr_b <= 1'b0;
      // Set wins over a same-cycle W1C clear.
      irq_stat      <= (irq_stat & ~irq_clr) | irq_set;
      irq_b         <= |(irq_stat & mem[IDX_CTRL][2:0]);

      case (state)
        S_IDLE: begin
          if (strobe) begin
            cap_addr  <= apb.paddr_b;
            cap_wdata <= apb.pwdata_b;
            cap_write <= apb.pwrite_b;
            if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else begin
              state         <= S_RESP;
              apb.pready_b  <= 1'b1;
              apb.prdata_b  <= resp_data;
              apb.pslverr_b <= req_err;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state         <= S_RESP;
            apb.pready_b  <= 1'b1;
            apb.prdata_b  <= resp_data;
            apb.pslverr_b <= req_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
          // Commit and count only successful accesses; pslverr_b still
          // holds this access's error flag during RESP.
          if (!apb.pslverr_b) begin
            if (cap_write) begin
              if ((cap_idx != IDX_STATS) && (cap_idx != IDX_IRQ))
                mem[cap_idx] <= cap_wdata;
              if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else begin
              if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
